// File: rtl/simon_round_ctrl.sv
// simon_round_ctrl
//   Round sequencer for the Simon Says game. Each round it adds one random
//   arrow to the stored sequence and plays the whole sequence back on the
//   arrow display. It then checks the player's presses against the sequence.
//
//   Optional feature macro: SIMON_TIMEOUT_EN
//     When defined, the player loses if WAIT_IN sees no press for
//     INPUT_TIMEOUT cycles. When undefined, WAIT_IN waits indefinitely and
//     no timeout logic is built.
//
//   Ports
//     clock        in   system clock, all state updates on posedge
//     resetn       in   asynchronous active-low reset
//     start        in   level, begins a new game from IDLE/WIN/LOSE
//     dir_in[2:0]  in   registered direction code from the arrow selector
//     show_arrow   out  arrow to render, 3'b111 when blank
//     show_active  out  high during playback
//     level[4:0]   out  current sequence length
//     win          out  high while in WIN
//     lose         out  high while in LOSE
//
//   Arrow codes: 000 LEFT, 001 DOWN, 010 UP, 011 RIGHT, 1xx NOTHING.

module simon_round_ctrl #(
    parameter int         MAX_LEN     = 16,
    parameter int         SHOW_CYCLES = 25000000,
    parameter int         GAP_CYCLES  = 12500000,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
`ifdef SIMON_TIMEOUT_EN
    ,
    parameter int         INPUT_TIMEOUT = 100000000
`endif
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] dir_in,
    output logic [2:0] show_arrow,
    output logic       show_active,
    output logic [4:0] level,
    output logic       win,
    output logic       lose
);

    // state      | meaning
    // -----------+------------------------------------------------------
    // S_IDLE     | after reset, waiting for start
    // S_GROW     | append one random arrow, level += 1 (one cycle)
    // S_SHOW_ON  | arrow seq[idx] displayed for SHOW_CYCLES
    // S_SHOW_OFF | blank gap for GAP_CYCLES, then next arrow or WAIT_IN
    // S_WAIT_IN  | echo the selector, wait for a press to compare
    // S_MATCH    | press matched seq[idx] (one cycle)
    // S_WIN      | full MAX_LEN sequence repeated, waiting for start
    // S_LOSE     | wrong press (or timeout), waiting for start

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef SIMON_TIMEOUT_EN
    // The default timeout does not fit in 25 bits.
    localparam int TW = 27;
`else
    localparam int TW = 25;
`endif

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
`ifdef SIMON_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST   = TW'(INPUT_TIMEOUT - 1);
`endif
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
    localparam logic [2:0]    BLANK     = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GROW,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_IN,
        S_MATCH,
        S_WIN,
        S_LOSE
    } state_t;

    state_t          state_q;
    logic [7:0]      lfsr_q;
    logic [7:0]      lfsr_d;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_inc;
    logic [TW-1:0]   timer_q;
    logic [4:0]      level_q;
    logic [2:0]      show_arrow_q;
    logic            show_active_q;
    logic            win_q;
    logic            lose_q;
    logic            prev_valid_q;
    logic [1:0]      seq_q [MAX_LEN];

    logic            dir_valid;
    logic            press;
    logic            last_step;
    logic [2:0]      echo;
    logic [1:0]      first_arrow;

    // Fibonacci LFSR, taps 8,6,5,4.
    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    assign dir_valid = ~dir_in[2];
    // Rising edge of "some arrow is selected"; valid-to-valid changes are not presses.
    assign press     = dir_valid & ~prev_valid_q;
    assign echo      = dir_valid ? dir_in : BLANK;
    assign idx_inc   = idx_q + 1'b1;
    assign last_step = (5'(idx_q) == (level_q - 5'd1));
    // In the first round seq[0] is being written by GROW itself, so bypass the array.
    assign first_arrow = (level_q == 5'd0) ? lfsr_q[1:0] : seq_q[0];

    // Sequence store has no reset; entries beyond level are never read.
    always_ff @(posedge clock) begin
        if (state_q == S_GROW) begin
            seq_q[level_q[IW-1:0]] <= lfsr_q[1:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            lfsr_q        <= LFSR_SEED;
            idx_q         <= '0;
            timer_q       <= '0;
            level_q       <= '0;
            show_arrow_q  <= BLANK;
            show_active_q <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            prev_valid_q  <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            prev_valid_q <= dir_valid;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_GROW;
                        timer_q <= '0;
                    end
                end

                S_GROW: begin
                    level_q       <= level_q + 5'd1;
                    idx_q         <= '0;
                    timer_q       <= '0;
                    state_q       <= S_SHOW_ON;
                    show_arrow_q  <= {1'b0, first_arrow};
                    show_active_q <= 1'b1;
                end

                S_SHOW_ON: begin
                    if (timer_q == SHOW_LAST) begin
                        timer_q      <= '0;
                        state_q      <= S_SHOW_OFF;
                        show_arrow_q <= BLANK;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_SHOW_OFF: begin
                    if (timer_q == GAP_LAST) begin
                        timer_q <= '0;
                        if (last_step) begin
                            idx_q         <= '0;
                            state_q       <= S_WAIT_IN;
                            show_active_q <= 1'b0;
                            show_arrow_q  <= echo;
                        end else begin
                            idx_q        <= idx_inc;
                            state_q      <= S_SHOW_ON;
                            show_arrow_q <= {1'b0, seq_q[idx_inc]};
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_WAIT_IN: begin
                    show_arrow_q <= echo;
                    if (press) begin
                        timer_q <= '0;
                        if (dir_in[1:0] == seq_q[idx_q]) begin
                            state_q <= S_MATCH;
                        end else begin
                            state_q      <= S_LOSE;
                            lose_q       <= 1'b1;
                            show_arrow_q <= BLANK;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (timer_q == TO_LAST) begin
                        timer_q      <= '0;
                        state_q      <= S_LOSE;
                        lose_q       <= 1'b1;
                        show_arrow_q <= BLANK;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
`endif
                end

                S_MATCH: begin
                    timer_q <= '0;
                    if (last_step) begin
                        show_arrow_q <= BLANK;
                        if (level_q == LEN_MAX) begin
                            state_q <= S_WIN;
                            win_q   <= 1'b1;
                        end else begin
                            state_q <= S_GROW;
                        end
                    end else begin
                        idx_q        <= idx_inc;
                        state_q      <= S_WAIT_IN;
                        show_arrow_q <= echo;
                    end
                end

                S_WIN, S_LOSE: begin
                    if (start) begin
                        level_q <= '0;
                        win_q   <= 1'b0;
                        lose_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_GROW;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign show_arrow  = show_arrow_q;
    assign show_active = show_active_q;
    assign level       = level_q;
    assign win         = win_q;
    assign lose        = lose_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Testbench for simon_round_ctrl with short timings (SHOW=4, GAP=2, MAX_LEN=3).
// The expected arrow sequence comes from an arithmetic LFSR model sampled
// in the GROW cycle; playback, matching, win/lose and reset are checked
// against that queue.

module tb_simon_round_ctrl;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int MAXL = 3;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] dir_in;
    logic [2:0] show_arrow;
    logic       show_active;
    logic [4:0] level;
    logic       win;
    logic       lose;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [7:0] m_lfsr;
    logic [1:0] q[$];

    simon_round_ctrl #(
        .MAX_LEN     (MAXL),
        .SHOW_CYCLES (SHOW),
        .GAP_CYCLES  (GAP),
        .LFSR_SEED   (8'hA5)
`ifdef SIMON_TIMEOUT_EN
        ,
        .INPUT_TIMEOUT (10)
`endif
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dir_in      (dir_in),
        .show_arrow  (show_arrow),
        .show_active (show_active),
        .level       (level),
        .win         (win),
        .lose        (lose)
    );

    always #5 clock = ~clock;

    // Reference LFSR: shift left, new LSB is the parity of bits 8,6,5,4.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] wrong_code(input logic [1:0] c);
        logic [1:0] w;
        w = c + 2'($urandom_range(1, 3));
        return {1'b0, w};
    endfunction

    // Called at the negedge of a start-sampling cycle; ends at the GROW negedge.
    task automatic new_game();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("new_level0", 8'(level), 8'd0);
        check("new_win0", 8'(win), 8'd0);
        check("new_lose0", 8'(lose), 8'd0);
        q.delete();
    endtask

    // Called at a GROW negedge; ends at the first WAIT_IN negedge.
    task automatic grow_and_show(input int release_at, input bit hold_wrong);
        int k = 0;
        q.push_back(m_lfsr[1:0]);
        check("grow_level", 8'(level), 8'(q.size() - 1));
        if (hold_wrong) dir_in = wrong_code(q[0]);
        for (int i = 0; i < q.size(); i++) begin
            for (int c = 0; c < SHOW + GAP; c++) begin
                @(negedge clock);
                k++;
                if (k == release_at) dir_in = 3'b111;
                check("show_arrow", 8'(show_arrow), (c < SHOW) ? {6'd0, q[i]} : 8'h07);
                check("show_active", 8'(show_active), 8'd1);
            end
        end
        @(negedge clock);
        k++;
        if (k == release_at) dir_in = 3'b111;
        check("wait_active", 8'(show_active), 8'd0);
        check("wait_level", 8'(level), 8'(q.size()));
    endtask

    // Called at a WAIT_IN negedge with dir_in released; ends at GROW/WIN negedge.
    task automatic answer_all();
        for (int i = 0; i < q.size(); i++) begin
            dir_in = {1'b0, q[i]};
            @(negedge clock);
            check("match_nolose", 8'(lose), 8'd0);
            check("match_echo", 8'(show_arrow), {6'd0, q[i]});
            dir_in = 3'b111;
            if (i < q.size() - 1) begin
                @(negedge clock);
                check("rewait_active", 8'(show_active), 8'd0);
            end
        end
        @(negedge clock);
    endtask

    initial begin
        logic [2:0] wc;
        resetn = 1'b0;
        start  = 1'b0;
        dir_in = 3'b111;
        repeat (3) @(negedge clock);
        check("rst_arrow", 8'(show_arrow), 8'h07);
        check("rst_active", 8'(show_active), 8'd0);
        check("rst_level", 8'(level), 8'd0);
        check("rst_win", 8'(win), 8'd0);
        check("rst_lose", 8'(lose), 8'd0);
        resetn = 1'b1;
        repeat ($urandom_range(0, 20)) @(negedge clock);

        // Game 1: round 1 answered with a 5-cycle hold, then full play to WIN.
        new_game();
        grow_and_show(-1, 1'b0);
        dir_in = {1'b0, q[0]};
        @(negedge clock);
        check("r1_match_level", 8'(level), 8'd1);
        check("r1_nolose", 8'(lose), 8'd0);
        @(negedge clock);
        grow_and_show(3, 1'b0);
        answer_all();
        grow_and_show(-1, 1'b0);
        answer_all();
        check("win", 8'(win), 8'd1);
        check("win_level", 8'(level), 8'd3);
        check("win_arrow", 8'(show_arrow), 8'h07);
        repeat (3) @(negedge clock);
        check("win_hold", 8'(win), 8'd1);
        check("win_hold_level", 8'(level), 8'd3);

        // Game 2: invalid codes are not presses, then a wrong press loses.
        new_game();
        grow_and_show(-1, 1'b0);
        dir_in = 3'b100 + 3'($urandom_range(0, 2));
        repeat (3) @(negedge clock);
        check("inval_nolose", 8'(lose), 8'd0);
        check("inval_active", 8'(show_active), 8'd0);
        check("inval_echo", 8'(show_arrow), 8'h07);
        dir_in = wrong_code(q[0]);
        @(negedge clock);
        check("lose", 8'(lose), 8'd1);
        check("lose_arrow", 8'(show_arrow), 8'h07);
        check("lose_win", 8'(win), 8'd0);
        dir_in = 3'b111;
        repeat (3) @(negedge clock);
        check("lose_hold", 8'(lose), 8'd1);
        check("lose_level", 8'(level), 8'd1);

        // Game 3: wrong key held through playback registers no press.
        new_game();
        grow_and_show(-1, 1'b1);
        wc = dir_in;
        repeat (2) @(negedge clock);
        check("held_nolose", 8'(lose), 8'd0);
        check("held_active", 8'(show_active), 8'd0);
        check("held_echo", 8'(show_arrow), 8'(wc));
        dir_in = 3'b111;
        @(negedge clock);
        answer_all();
        check("held_grow_level", 8'(level), 8'd1);

        // Asynchronous reset during SHOW_ON.
        q.push_back(m_lfsr[1:0]);
        @(negedge clock);
        check("pre_rst_arrow", 8'(show_arrow), {6'd0, q[0]});
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_arrow", 8'(show_arrow), 8'h07);
        check("mid_rst_level", 8'(level), 8'd0);
        check("mid_rst_active", 8'(show_active), 8'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat ($urandom_range(0, 10)) @(negedge clock);

        // Game 4: WAIT_IN with no press.
        new_game();
        grow_and_show(-1, 1'b0);
`ifdef SIMON_TIMEOUT_EN
        repeat (9) @(negedge clock);
        check("to_before", 8'(lose), 8'd0);
        @(negedge clock);
        check("to_lose", 8'(lose), 8'd1);
`else
        repeat (12) @(negedge clock);
        check("no_to_lose", 8'(lose), 8'd0);
        check("no_to_active", 8'(show_active), 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
